// File: rtl/iq_seq.sv
// Inverse-quantization sequencer: zig-zag coefficient stream in, romq-scaled coefficients out.
// Optional saturation of the output (and the dq_sat port) is enabled by defining IQ_SAT_EN.
module iq_seq #(
  parameter int COEF_W = 12,
  parameter int Q_W    = 8,
  parameter int OUT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [COEF_W-1:0] coef_in,
  input  logic                     coef_valid,
  input  logic                     coef_last,
  output logic                     coef_ready,
  output logic [5:0]               rom_a,
  input  logic [Q_W-1:0]           rom_d,
  output logic signed [OUT_W-1:0]  dq_out,
  output logic [5:0]               dq_idx,
  output logic                     dq_valid,
  output logic                     dq_last,
  input  logic                     dq_ready,
`ifdef IQ_SAT_EN
  output logic                     dq_sat,
`endif
  output logic                     seq_err
);

  localparam int P_W = COEF_W + Q_W + 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and data holds while valid is high and ready is low.

  logic [5:0]               r_idx;
  logic                     r_s1_valid;
  logic signed [COEF_W-1:0] r_s1_coef;
  logic [5:0]               r_s1_idx;
  logic signed [OUT_W-1:0]  r_dq_out;
  logic [5:0]               r_dq_idx;
  logic                     r_dq_valid;
  logic                     r_dq_last;
  logic                     r_seq_err;

  logic                     w_s1_adv;
  logic                     w_coef_ready;
  logic                     w_accept;
  logic signed [P_W-1:0]    w_coef_ext;
  logic signed [P_W-1:0]    w_rom_ext;
  logic signed [P_W-1:0]    w_prod;
  logic signed [OUT_W-1:0]  w_dq_fmt;

  assign w_s1_adv     = r_s1_valid & (~r_dq_valid | dq_ready);
  assign w_coef_ready = ~r_s1_valid | w_s1_adv;
  assign w_accept     = coef_valid & w_coef_ready;

  // While S1 is stalled keep re-addressing its entry so rom_d stays aligned with it.
  assign rom_a = (r_s1_valid & ~w_s1_adv) ? r_s1_idx : r_idx;

  assign w_coef_ext = {{(Q_W + 1){r_s1_coef[COEF_W-1]}}, r_s1_coef};
  assign w_rom_ext  = {{(COEF_W + 1){1'b0}}, rom_d};
  assign w_prod     = w_coef_ext * w_rom_ext;

`ifdef IQ_SAT_EN
  logic [P_W-OUT_W:0] w_hi;
  logic               w_sat;
  logic               r_dq_sat;

  // In range only when every bit above the output sign bit matches it.
  assign w_hi     = w_prod[P_W-1:OUT_W-1];
  assign w_sat    = ~((&w_hi) | ~(|w_hi));
  assign w_dq_fmt = ~w_sat ? w_prod[OUT_W-1:0] :
                    (w_prod[P_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}});
  assign dq_sat   = r_dq_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dq_sat <= 1'b0;
    end else if (w_s1_adv) begin
      r_dq_sat <= w_sat;
    end
  end
`else
  logic w_unused_hi;

  assign w_dq_fmt    = w_prod[OUT_W-1:0];
  assign w_unused_hi = ^w_prod[P_W-1:OUT_W];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= 6'd0;
      r_s1_valid <= 1'b0;
      r_s1_coef  <= '0;
      r_s1_idx   <= 6'd0;
      r_seq_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1_coef  <= coef_in;
        r_s1_idx   <= r_idx;
        r_idx      <= r_idx + 6'd1;
        r_s1_valid <= 1'b1;
        // The index runs purely by count; a misplaced coef_last only flags the error.
        if (coef_last != (r_idx == 6'd63)) begin
          r_seq_err <= 1'b1;
        end
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dq_out   <= '0;
      r_dq_idx   <= 6'd0;
      r_dq_valid <= 1'b0;
      r_dq_last  <= 1'b0;
    end else if (w_s1_adv) begin
      r_dq_out   <= w_dq_fmt;
      r_dq_idx   <= r_s1_idx;
      r_dq_last  <= (r_s1_idx == 6'd63);
      r_dq_valid <= 1'b1;
    end else if (dq_ready) begin
      r_dq_valid <= 1'b0;
    end
  end

  assign coef_ready = w_coef_ready;
  assign dq_out     = r_dq_out;
  assign dq_idx     = r_dq_idx;
  assign dq_valid   = r_dq_valid;
  assign dq_last    = r_dq_last;
  assign seq_err    = r_seq_err;

endmodule

// File: tb/tb_iq_seq.sv
// Bench for iq_seq: registered romq model, stimulus driver, output scoreboard and summary.
module tb_iq_seq;

  logic               clk;
  logic               rst_n;
  logic signed [11:0] coef_in;
  logic               coef_valid;
  logic               coef_last;
  logic               coef_ready;
  logic [5:0]         rom_a;
  logic [7:0]         rom_d;
  logic signed [15:0] dq_out;
  logic [5:0]         dq_idx;
  logic               dq_valid;
  logic               dq_last;
  logic               dq_ready;
  logic               seq_err;
  logic               act_sat;

  iq_seq #(.COEF_W(12), .Q_W(8), .OUT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coef_in    (coef_in),
    .coef_valid (coef_valid),
    .coef_last  (coef_last),
    .coef_ready (coef_ready),
    .rom_a      (rom_a),
    .rom_d      (rom_d),
    .dq_out     (dq_out),
    .dq_idx     (dq_idx),
    .dq_valid   (dq_valid),
    .dq_last    (dq_last),
    .dq_ready   (dq_ready),
`ifdef IQ_SAT_EN
    .dq_sat     (act_sat),
`endif
    .seq_err    (seq_err)
  );

`ifndef IQ_SAT_EN
  assign act_sat = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- romq model (registered output) ----------------
  function automatic logic [7:0] rom_val(input logic [5:0] a);
    int v;
    if (a == 6'd5) return 8'd255;
    v = (int'(a) * 37 + 11) % 256;
    return v[7:0];
  endfunction

  always @(posedge clk) rom_d <= rom_val(rom_a);

  // ---------------- scoreboard state ----------------
  logic [23:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_idx  = 0;
  bit bp_mode  = 0;
  int first_acc_cyc = -1;
  int first_out_cyc = -1;
  int last_out_cyc  = -1;
  int n_out  = 0;
  int n_last = 0;
  logic [5:0]  first_idx;
  logic [15:0] sat_out;
  logic        sat_flag;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected word: {sat, last, idx[5:0], out[15:0]}
  function automatic logic [23:0] exp_word(input int idx, input int coef);
    int p;
    logic [15:0] o;
    logic s;
    p = coef * int'(rom_val(idx[5:0]));
    o = p[15:0];
    s = 1'b0;
`ifdef IQ_SAT_EN
    if (p > 32767) begin
      o = 16'h7fff; s = 1'b1;
    end else if (p < -32768) begin
      o = 16'h8000; s = 1'b1;
    end
`endif
    return {s, (idx == 63), idx[5:0], o};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst_n = 1'b0;
    exp_q.delete();
    exp_idx = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input int coef, input bit last);
    bit acc;
    int waited;
    acc = 1'b0;
    waited = 0;
    coef_in = coef[11:0];
    coef_last = last;
    coef_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = coef_ready;
      if (acc && first_acc_cyc < 0) first_acc_cyc = cyc;
      @(posedge clk);
      #1;
      if (!acc) begin
        waited++;
        if (waited > 200) begin
          check("accept_timeout", 32'd0, 32'd1);
          break;
        end
      end
    end
    if (acc) begin
      exp_q.push_back(exp_word(exp_idx, coef));
      exp_idx = (exp_idx + 1) % 64;
    end
    coef_valid = 1'b0;
    coef_last = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() > 0 && waited < 2000) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    first_acc_cyc = -1;
    first_out_cyc = -1;
    last_out_cyc  = -1;
    n_out  = 0;
    n_last = 0;
  endtask

  always @(posedge clk) begin
    #1;
    if (bp_mode) dq_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (dq_valid && !dq_ready && exp_q.size() >= 2)
        check("rom_a_stall", rom_a, exp_q[1][21:16]);
      if (dq_valid && dq_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {8'd0, act_sat, dq_last, dq_idx, dq_out}, 32'hffffffff);
        end else begin
          check("dq_word", {8'd0, act_sat, dq_last, dq_idx, dq_out}, {8'd0, exp_q.pop_front()});
        end
        n_out++;
        if (n_out == 1) first_idx = dq_idx;
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        if (dq_last) n_last++;
        if (dq_idx == 6'd5) begin
          sat_out  = dq_out;
          sat_flag = act_sat;
        end
      end
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    rst_n = 1'b0;
    coef_in = '0;
    coef_valid = 1'b0;
    coef_last = 1'b0;
    dq_ready = 1'b0;
    #1;
    check("rst_coef_ready", coef_ready, 1);
    check("rst_rom_a", rom_a, 0);
    check("rst_dq_out", dq_out, 0);
    check("rst_dq_idx", dq_idx, 0);
    check("rst_dq_valid", dq_valid, 0);
    check("rst_dq_last", dq_last, 0);
    check("rst_seq_err", seq_err, 0);
`ifdef IQ_SAT_EN
    check("rst_dq_sat", act_sat, 0);
`endif
    apply_reset();

    // Unit coefficients: outputs equal the table entries.
    dq_ready = 1'b1;
    clear_stats();
    for (int i = 0; i < 64; i++) send(1, i == 63);
    drain();
    check("unit_latency", first_out_cyc - first_acc_cyc, 2);
    check("unit_count", n_out, 64);
    check("unit_last_count", n_last, 1);
    check("unit_seq_err", seq_err, 0);

    // Random backpressure with signed ramp.
    clear_stats();
    bp_mode = 1'b1;
    for (int i = 0; i < 64; i++) send(i - 32, i == 63);
    drain();
    bp_mode = 1'b0;
    dq_ready = 1'b1;
    check("bp_count", n_out, 64);

    // Extreme coefficient at the 255 entry.
    clear_stats();
    for (int i = 0; i < 64; i++) send((i == 5) ? -2048 : i, i == 63);
    drain();
`ifdef IQ_SAT_EN
    check("sat_out", sat_out, 16'h8000);
    check("sat_flag", sat_flag, 1);
`else
    check("wrap_out", sat_out, 16'h0800);
`endif

    // Back-to-back blocks with continuous valid.
    clear_stats();
    for (int i = 0; i < 128; i++) send(i % 7 - 3, (i % 64) == 63);
    drain();
    check("b2b_count", n_out, 128);
    check("b2b_last_count", n_last, 2);
    check("b2b_no_bubble", last_out_cyc - first_out_cyc, 127);

    // Framing error: coef_last early at index 10.
    check("frame_err_before", seq_err, 0);
    for (int i = 0; i < 10; i++) send(i, 1'b0);
    check("frame_err_pre10", seq_err, 0);
    send(10, 1'b1);
    check("frame_err_set", seq_err, 1);
    for (int i = 11; i < 64; i++) send(i, i == 63);
    for (int i = 0; i < 64; i++) send(2, i == 63);
    drain();
    check("frame_err_sticky", seq_err, 1);
    apply_reset();
    check("frame_err_cleared", seq_err, 0);

    // Reset in the middle of a block.
    dq_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(3, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_dq_valid", dq_valid, 0);
    check("midrst_coef_ready", coef_ready, 1);
    exp_q.delete();
    exp_idx = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_stats();
    for (int i = 0; i < 64; i++) send(-1, i == 63);
    drain();
    check("midrst_first_idx", first_idx, 0);
    check("midrst_count", n_out, 64);
    check("midrst_seq_err", seq_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
